vl_onehot_monitor: RTL

- Parameterised, pipelined population-count checker for N-bit vectors; successor to the combinational N-bit one-hot detector primitive.
- Each accepted sample is classified as pass or fail against a programmable hot-count window [MIN_HOT, MAX_HOT]: one-hot, zero-or-one-hot, or at-most-k-hot.
- Keeps a sticky fail flag and a saturating fail counter.
- Sits beside arbiter grant and mux select buses as a synthesizable assertion and monitor block.

---
 rtl/vl_onehot_monitor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vl_onehot_monitor.sv
// vl_onehot_monitor: two-stage popcount checker for WIDTH-bit vectors.
// Each accepted sample passes when its hot count lies in [MIN_HOT, MAX_HOT].
// A sticky fail flag and a saturating fail counter track fails.
// Optional macro VL_ONEHOT_MONITOR_CAPTURE_EN adds capture of the first failing vector.
module vl_onehot_monitor #(
    parameter  int WIDTH   = 8,
    parameter  int MIN_HOT = 1,
    parameter  int MAX_HOT = 1,
    parameter  int CNT_W   = 16,
    localparam int CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic             clear,
    output logic             out_valid,
    output logic             out,
    output logic [CW-1:0]    count,
    output logic             fail_sticky,
    output logic [CNT_W-1:0] fail_cnt
`ifdef VL_ONEHOT_MONITOR_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] first_fail_vec,
    output logic             first_fail_vld
`endif
);

    localparam int STAGES = 2;

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_width_err
            $error("vl_onehot_monitor: WIDTH must be in 1..64");
        end
        if (MIN_HOT > MAX_HOT || MAX_HOT > WIDTH) begin : g_window_err
            $error("vl_onehot_monitor: need MIN_HOT <= MAX_HOT <= WIDTH");
        end
    endgenerate

    logic [STAGES:1] vld_pipe;
    logic [CW-1:0]   pop;
    logic [CW-1:0]   s1_count;
    logic            lo_ok;
    logic            hi_ok;
    logic            pass;
    logic            fail_evt;

    assign out_valid = vld_pipe[STAGES];

    // Population count of the incoming vector.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + CW'(in[i]);
    end

    // A zero lower bound is always met; skip the compare so it is not a constant-true expression.
    generate
        if (MIN_HOT == 0) begin : g_lo_free
            assign lo_ok = 1'b1;
        end else begin : g_lo_cmp
            assign lo_ok = (s1_count >= CW'(MIN_HOT));
        end
    endgenerate

    assign hi_ok    = (s1_count <= CW'(MAX_HOT));
    assign pass     = lo_ok && hi_ok;
    assign fail_evt = vld_pipe[1] && !pass;

    // Valid shift register and stage-1 count; the count holds across idle cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            s1_count <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            if (in_valid) s1_count <= pop;
        end
    end

    // Stage-2 result; out and count hold while no sample arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out   <= 1'b0;
            count <= '0;
        end else if (vld_pipe[1]) begin
            out   <= pass;
            count <= s1_count;
        end
    end

    // Sticky flag and saturating counter; a fail landing with clear is counted after the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_sticky <= 1'b0;
            fail_cnt    <= '0;
        end else if (clear) begin
            fail_sticky <= fail_evt;
            fail_cnt    <= fail_evt ? CNT_W'(1) : '0;
        end else if (fail_evt) begin
            fail_sticky <= 1'b1;
            if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + CNT_W'(1);
        end
    end

`ifdef VL_ONEHOT_MONITOR_CAPTURE_EN
    logic [WIDTH-1:0] s1_vec;

    // Raw vector rides alongside s1_count so the failing sample can be captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vec <= '0;
        end else if (in_valid) begin
            s1_vec <= in;
        end
    end

    // Latch only the first fail since reset or clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
        end else if (clear) begin
            first_fail_vec <= fail_evt ? s1_vec : '0;
            first_fail_vld <= fail_evt;
        end else if (fail_evt && !first_fail_vld) begin
            first_fail_vec <= s1_vec;
            first_fail_vld <= 1'b1;
        end
    end
`endif

endmodule
